// File: rtl/cache_bus_arb.sv
// Two-master bus arbiter sharing one line-burst bus between the I$ and the D$.
// Owners are granted from idle, hold the bus for a whole line and get a one-cycle ack.
module cache_bus_arb #(
    parameter int unsigned PA_BITS      = 34,
    parameter int unsigned BEATSPERLINE = 4,
    parameter int unsigned LOGBWPL      = $clog2(BEATSPERLINE)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         IBusRW,
    input  logic [PA_BITS-1:0] IBusAdr,
    input  logic [1:0]         DBusRW,
    input  logic [PA_BITS-1:0] DBusAdr,
    input  logic               DLock,
    input  logic               BusBeatAck,
    output logic               IBusAck,
    output logic               DBusAck,
    output logic [1:0]         BusRW,
    output logic [PA_BITS-1:0] BusAdr,
    output logic [LOGBWPL-1:0] BeatCount,
    output logic               DOwner
);

    localparam logic [LOGBWPL-1:0] LAST_BEAT = LOGBWPL'(BEATSPERLINE - 1);

    localparam logic [1:0] RW_NONE  = 2'b00;
    localparam logic [1:0] RW_WRITE = 2'b01;
    localparam logic [1:0] RW_FETCH = 2'b10;

    typedef enum logic [1:0] {StIdle, StXfer, StDone} state_e;

    state_e               state_q, state_d;
    logic                 owner_q, owner_d;
    logic                 last_owner_q, last_owner_d;
    logic [1:0]           rw_q, rw_d;
    logic [PA_BITS-1:0]   adr_q, adr_d;
    logic [LOGBWPL-1:0]   beat_q, beat_d;

    logic                 i_req;
    logic                 d_req;
    logic                 contended;
    logic                 grant_d;
    logic [1:0]           d_rw;
    logic                 lock_cont;
    logic                 last_beat_done;

    // IBusRW[0] has no meaning for the instruction side.
    logic unused_ibus_rw0;
    assign unused_ibus_rw0 = IBusRW[0];

    // Request decode and arbitration
    always_comb begin
        i_req     = IBusRW[1];
        d_req     = |DBusRW;
        contended = i_req & d_req;
        grant_d   = 1'b0;
        if (d_req && !i_req) begin
            grant_d = 1'b1;
        end else if (contended) begin
            grant_d = ~last_owner_q;
        end
        // A combined writeback+fetch goes out as the writeback first.
        d_rw           = DBusRW[0] ? RW_WRITE : RW_FETCH;
        lock_cont      = owner_q & DLock & DBusRW[1];
        last_beat_done = BusBeatAck && (beat_q == LAST_BEAT);
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (i_req || d_req) begin
                    state_d = StXfer;
                end
            end
            StXfer: begin
                if (last_beat_done) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = lock_cont ? StXfer : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Transfer context: owner, request type, address and beat index
    always_comb begin
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        rw_d         = rw_q;
        adr_d        = adr_q;
        beat_d       = beat_q;
        unique case (state_q)
            StIdle: begin
                beat_d = '0;
                if (i_req || d_req) begin
                    owner_d = grant_d;
                    rw_d    = grant_d ? d_rw : RW_FETCH;
                    adr_d   = grant_d ? DBusAdr : IBusAdr;
                    // Round-robin pointer only moves when both sides competed.
                    if (contended) begin
                        last_owner_d = grant_d;
                    end
                end
            end
            StXfer: begin
                if (BusBeatAck) begin
                    beat_d = beat_q + LOGBWPL'(1);
                end
            end
            StDone: begin
                if (lock_cont) begin
                    rw_d  = RW_FETCH;
                    adr_d = DBusAdr;
                end
            end
            default: begin
                beat_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q      <= 1'b0;
            last_owner_q <= 1'b0;
            rw_q         <= RW_NONE;
            adr_q        <= '0;
            beat_q       <= '0;
        end else begin
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            rw_q         <= rw_d;
            adr_q        <= adr_d;
            beat_q       <= beat_d;
        end
    end

    // Output logic
    always_comb begin
        BusRW     = RW_NONE;
        BusAdr    = IBusAdr;
        BeatCount = '0;
        DOwner    = 1'b0;
        IBusAck   = 1'b0;
        DBusAck   = 1'b0;
        unique case (state_q)
            StIdle: begin
            end
            StXfer: begin
                BusRW     = rw_q;
                BusAdr    = adr_q;
                BeatCount = beat_q;
                DOwner    = owner_q;
            end
            StDone: begin
                BusAdr    = adr_q;
                BeatCount = beat_q;
                DOwner    = owner_q;
                IBusAck   = ~owner_q;
                DBusAck   = owner_q;
            end
            default: begin
            end
        endcase
    end

    ack_exclusive_a: assert property (@(posedge clk) disable iff (reset) !(IBusAck && DBusAck));

endmodule

// File: doc/cache_bus_arb.md
CACHE_BUS_ARB -- requirements
Module: cache_bus_arb

Interface
REQ-001 SHALL have parameter PA_BITS, default 34: physical address width.
REQ-002 SHALL have parameter BEATSPERLINE, default 4: bus beats per cache line (power of 2, >=2).
REQ-003 SHALL have derived localparam LOGBWPL = log2(BEATSPERLINE).
REQ-004 SHALL have port clk  input  1  sole clock, all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port IBusRW  input  2  I$ request, [1] line fetch, [0] unused (ignored).
REQ-007 SHALL have port IBusAdr  input  PA_BITS  I$ line address.
REQ-008 SHALL have port DBusRW  input  2  D$ request, [1] line fetch, [0] line writeback.
REQ-009 SHALL have port DBusAdr  input  PA_BITS  D$ line address.
REQ-010 SHALL have port DLock  input  1  D$ keeps ownership after current transfer (writeback followed by fetch).
REQ-011 SHALL have port BusBeatAck  input  1  one bus beat completed this cycle.
REQ-012 SHALL have ports IBusAck, DBusAck  output  1 each  transfer complete, one-cycle pulse to the owner.
REQ-013 SHALL have port BusRW  output  2  request presented to bus, same encoding as DBusRW.
REQ-014 SHALL have port BusAdr  output  PA_BITS  address of current owner.
REQ-015 SHALL have port BeatCount  output  LOGBWPL  index of current beat within the line.
REQ-016 SHALL have port DOwner  output  1  1 = D$ owns the bus.

Function
REQ-017 SHALL implement FSM states IDLE, XFER, DONE.
REQ-018 IDLE: no request -> stay; any request -> XFER next cycle, owner latched.
REQ-019 Arbitration: only one requester -> it wins; both -> the one not granted last (round-robin via LastOwner flop).
REQ-020 DBusRW = 2'b11 SHALL be treated as writeback (BusRW = 2'b01); fetch follows as a separate transfer.
REQ-021 XFER: BusRW = owner's request (I$: 2'b10), BusAdr = owner's address with low log2(line bytes) bits unchanged (caller zeroes them).
REQ-022 BeatCount SHALL increment on each BusBeatAck in XFER and wrap from BEATSPERLINE-1 to 0.
REQ-023 BusBeatAck with BeatCount = BEATSPERLINE-1 SHALL move XFER -> DONE; BusRW = 2'b00 from that edge on.
REQ-024 DONE: owner's Ack high for exactly one cycle; other Ack low; next state IDLE.
REQ-025 Exception: in DONE with DOwner = 1 and DLock = 1 and DBusRW[1] = 1, next state SHALL be XFER with D$ retaining ownership and BusRW = 2'b10 (no arbitration, LastOwner unchanged).
REQ-026 Requester SHALL deassert its request in the cycle its Ack is high; arbiter ignores requests during DONE except per REQ-025.
REQ-027 Request dropped by the owner mid-XFER SHALL NOT abort the transfer (bus bursts are not interruptible).
REQ-028 BusBeatAck in IDLE or DONE SHALL be ignored (BeatCount unchanged).
REQ-029 IBusAck and DBusAck SHALL never be high in the same cycle.
REQ-030 Outputs in IDLE: BusRW = 0, BeatCount = 0, acks = 0; BusAdr = IBusAdr, DOwner = 0.

Reset
REQ-031 reset SHALL force state IDLE, BeatCount = 0, LastOwner = I$ (so first contended grant goes to D$), DOwner = 0, all acks 0, BusRW = 0, asynchronously.
REQ-032 reset asserted mid-XFER SHALL abandon the transfer with no ack issued.

Verification
REQ-033 I$ only: IBusRW = 2'b10, adr 0x1000, BusBeatAck every cycle -> BusRW = 2'b10 for 4 cycles, BeatCount 0,1,2,3, IBusAck pulse on cycle 6 after request.
REQ-034 Contention after reset: both request same cycle -> D$ served first, then I$; second contention -> I$ first.
REQ-035 Writeback+fetch lock: DBusRW = 2'b11, DLock = 1, then DBusRW = 2'b10 in DONE -> BusRW 01 x4 beats, DBusAck, BusRW 10 x4 beats, DBusAck; pending I$ request waits throughout.
REQ-036 Beat stalls: BusBeatAck on alternate cycles -> BeatCount holds between acks, DONE only after 4th ack.
REQ-037 Reset mid-transfer at BeatCount = 2 -> all outputs zero immediately, no ack; new request afterwards completes normally.
REQ-038 Stray BusBeatAck in IDLE -> BeatCount stays 0, no ack.
